// File: rtl/ps_pl_mem_arbiter_pkg.sv
// Shared types and defaults for the PS/PL shared-memory arbiter.
package ps_pl_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    PS_OWN = 3'd0,
    LAUNCH = 3'd1,
    PL_RUN = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } arb_state_e;

  function automatic logic is_busy(input arb_state_e s);
    return (s == LAUNCH) || (s == PL_RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/ps_pl_mem_arbiter_watchdog.sv
// PL_RUN timeout counter: held at zero while idle, pulses expire on its last run cycle.
// Only instantiated by ps_pl_mem_arbiter when ARB_WATCHDOG_EN is defined.
module arb_watchdog #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!run) begin
      count_d = '0;
    end else begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = run && (count_q == LAST);

endmodule

// File: rtl/ps_pl_mem_arbiter.sv
// Arbitrates the shared operand/result memory between PS and PL by ownership state.
// Optional PL_RUN timeout is enabled with the ARB_WATCHDOG_EN macro.
module ps_pl_mem_arbiter
  import ps_pl_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps_req,
  input  logic              ps_we,
  input  logic [ADDR_W-1:0] ps_addr,
  input  logic [DATA_W-1:0] ps_wdata,
  output logic              ps_gnt,
  input  logic              ps_start,
  input  logic              ps_clear,
  input  logic              pl_req,
  input  logic              pl_we,
  input  logic [ADDR_W-1:0] pl_addr,
  input  logic [DATA_W-1:0] pl_wdata,
  output logic              pl_gnt,
  input  logic              pl_finish,
  output logic              pl_launch,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  arb_state_e        state_q, state_d;
  logic              pl_launch_q, pl_launch_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              err_set_s;
  logic              wdog_expire_s;

  assign ps_gnt = ps_req && ((state_q == PS_OWN) || (state_q == DONE));
  assign pl_gnt = pl_req && (state_q == PL_RUN);

`ifdef ARB_WATCHDOG_EN
  arb_watchdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .run   (state_q == PL_RUN),
    .expire(wdog_expire_s)
  );
`else
  assign wdog_expire_s = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PS_OWN;
      pl_launch_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pl_launch_q <= pl_launch_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // A start while the PL owns the memory is dropped but flagged; a timeout is also flagged.
  always_comb begin
    state_d   = state_q;
    err_set_s = 1'b0;
    case (state_q)
      PS_OWN: begin
        if (ps_start) state_d = LAUNCH;
        else          state_d = PS_OWN;
      end
      LAUNCH: begin
        state_d   = PL_RUN;
        err_set_s = ps_start;
      end
      PL_RUN: begin
        if (pl_finish) begin
          state_d   = DRAIN;
          err_set_s = ps_start;
        end else if (wdog_expire_s) begin
          state_d   = DRAIN;
          err_set_s = 1'b1;
        end else begin
          state_d   = PL_RUN;
          err_set_s = ps_start;
        end
      end
      DRAIN: begin
        state_d   = DONE;
        err_set_s = ps_start;
      end
      DONE: begin
        if (ps_start)      state_d = LAUNCH;
        else if (ps_clear) state_d = PS_OWN;
        else               state_d = DONE;
      end
      default: begin
        state_d = PS_OWN;
      end
    endcase
  end

  always_comb begin
    mem_en_d    = ps_gnt || pl_gnt;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (ps_gnt) begin
      mem_we_d    = ps_we;
      mem_addr_d  = ps_addr;
      mem_wdata_d = ps_wdata;
    end else if (pl_gnt) begin
      mem_we_d    = pl_we;
      mem_addr_d  = pl_addr;
      mem_wdata_d = pl_wdata;
    end else begin
      mem_we_d    = 1'b0;
    end

    pl_launch_d = (state_q == LAUNCH);
    busy_d      = is_busy(state_d);
    done_d      = (state_d == DONE);

    // A relaunch from DONE takes priority over clear, so status is kept.
    if (err_set_s) begin
      err_d = 1'b1;
    end else if ((state_q == DONE) && ps_clear && !ps_start) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  assign pl_launch = pl_launch_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ps_pl_mem_arbiter.sv
// Self-checking bench for ps_pl_mem_arbiter; memory commands are tracked with a scoreboard queue.
// The timeout scenario runs only when ARB_WATCHDOG_EN is defined.
module tb_ps_pl_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps_req, ps_we, ps_gnt, ps_start, ps_clear;
  logic [7:0]  ps_addr;
  logic [31:0] ps_wdata;
  logic        pl_req, pl_we, pl_gnt, pl_finish, pl_launch;
  logic [7:0]  pl_addr;
  logic [31:0] pl_wdata;
  logic        mem_en, mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;

  cmd_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  ps_pl_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .WDOG_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .ps_req(ps_req), .ps_we(ps_we), .ps_addr(ps_addr), .ps_wdata(ps_wdata), .ps_gnt(ps_gnt),
    .ps_start(ps_start), .ps_clear(ps_clear),
    .pl_req(pl_req), .pl_we(pl_we), .pl_addr(pl_addr), .pl_wdata(pl_wdata), .pl_gnt(pl_gnt),
    .pl_finish(pl_finish), .pl_launch(pl_launch),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and compare the memory port against the scoreboard.
  task automatic tick();
    cmd_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("mem_en", mem_en, 1);
      check_eq("mem_we", mem_we, e.we);
      check_eq("mem_addr", mem_addr, e.addr);
      check_eq("mem_wdata", mem_wdata, e.wdata);
    end else begin
      check_eq("mem_en_idle", mem_en, 0);
      check_eq("mem_we_idle", mem_we, 0);
    end
  endtask

  task automatic ps_drive(input logic we, input logic [7:0] a, input logic [31:0] d, input logic exp_gnt);
    ps_req = 1'b1; ps_we = we; ps_addr = a; ps_wdata = d;
    #1;
    check_eq("ps_gnt", ps_gnt, exp_gnt);
    if (exp_gnt) sb.push_back('{we, a, d});
  endtask

  task automatic pl_drive(input logic we, input logic [7:0] a, input logic [31:0] d, input logic exp_gnt);
    pl_req = 1'b1; pl_we = we; pl_addr = a; pl_wdata = d;
    #1;
    check_eq("pl_gnt", pl_gnt, exp_gnt);
    if (exp_gnt) sb.push_back('{we, a, d});
  endtask

  task automatic idle_inputs();
    ps_req = 1'b0; ps_we = 1'b0; ps_start = 1'b0; ps_clear = 1'b0;
    pl_req = 1'b0; pl_we = 1'b0; pl_finish = 1'b0;
  endtask

  task automatic expect_status(input string tag, input logic b, input logic d, input logic e);
    check_eq({tag, "_busy"}, busy, b);
    check_eq({tag, "_done"}, done, d);
    check_eq({tag, "_err"}, err, e);
  endtask

  // Drive ps_start from PS_OWN/DONE and step through LAUNCH into PL_RUN.
  task automatic start_run();
    ps_start = 1'b1;
    tick();
    ps_start = 1'b0;
    check_eq("launch_in_LAUNCH", pl_launch, 0);
    tick();
    check_eq("launch_pulse", pl_launch, 1);
    check_eq("run_busy", busy, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst = 1'b1;
    ps_addr = 8'h00; ps_wdata = 32'h0; pl_addr = 8'h00; pl_wdata = 32'h0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    expect_status("reset", 1'b0, 1'b0, 1'b0);
    check_eq("reset_launch", pl_launch, 0);
    check_eq("reset_addr", mem_addr, 0);
    check_eq("reset_wdata", mem_wdata, 0);

    // Ownership: PL is refused while the PS owns the memory.
    pl_drive(1'b1, 8'h05, 32'hCAFE_0005, 1'b0);
    tick();
    idle_inputs();

    // PS write in PS_OWN.
    ps_drive(1'b1, 8'h01, 32'hDEAD_BEEF, 1'b1);
    tick();
    idle_inputs();

    // PS write together with ps_start: access granted, then LAUNCH.
    ps_drive(1'b1, 8'h03, 32'hA5A5_0003, 1'b1);
    ps_start = 1'b1;
    tick();
    idle_inputs();
    expect_status("launch", 1'b1, 1'b0, 1'b0);
    check_eq("launch_in_LAUNCH", pl_launch, 0);
    tick();
    check_eq("launch_pulse", pl_launch, 1);

    // PS refused during PL_RUN.
    ps_drive(1'b0, 8'h01, 32'h0, 1'b0);
    tick();
    idle_inputs();
    check_eq("launch_one_cycle", pl_launch, 0);

    // PL write with finish on the same cycle, then DRAIN.
    pl_drive(1'b1, 8'h02, 32'h1234_5678, 1'b1);
    pl_finish = 1'b1;
    tick();
    idle_inputs();
    expect_status("drain", 1'b1, 1'b0, 1'b0);
    pl_drive(1'b1, 8'h07, 32'h0000_0007, 1'b0);
    tick();
    idle_inputs();
    expect_status("done", 1'b0, 1'b1, 1'b0);

    // PS read-back in DONE, then clear.
    ps_drive(1'b0, 8'h02, 32'h0, 1'b1);
    tick();
    idle_inputs();
    check_eq("done_held", done, 1);
    ps_clear = 1'b1;
    tick();
    idle_inputs();
    expect_status("clear", 1'b0, 1'b0, 1'b0);

    // ps_start during PL_RUN is ignored but sticky err is raised.
    start_run();
    ps_start = 1'b1;
    tick();
    idle_inputs();
    expect_status("bad_start", 1'b1, 1'b0, 1'b1);
    tick();
    check_eq("bad_start_no_launch", pl_launch, 0);
    expect_status("bad_start_hold", 1'b1, 1'b0, 1'b1);
    pl_finish = 1'b1;
    tick();
    idle_inputs();
    tick();
    expect_status("err_done", 1'b0, 1'b1, 1'b1);
    pl_finish = 1'b1;
    tick();
    idle_inputs();
    expect_status("stray_finish", 1'b0, 1'b1, 1'b1);
    ps_clear = 1'b1;
    tick();
    idle_inputs();
    expect_status("err_clear", 1'b0, 1'b0, 1'b0);

    // ps_start beats ps_clear in DONE.
    start_run();
    pl_finish = 1'b1;
    tick();
    idle_inputs();
    tick();
    check_eq("race_done", done, 1);
    ps_start = 1'b1;
    ps_clear = 1'b1;
    tick();
    idle_inputs();
    expect_status("relaunch", 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("relaunch_pulse", pl_launch, 1);

    // Reset in PL_RUN with a granted PL request drops the command.
    pl_drive(1'b1, 8'h44, 32'h4444_4444, 1'b1);
    void'(sb.pop_back());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    expect_status("midrst", 1'b0, 1'b0, 1'b0);
    check_eq("midrst_launch", pl_launch, 0);
    check_eq("midrst_addr", mem_addr, 0);
    check_eq("midrst_wdata", mem_wdata, 0);
    ps_drive(1'b1, 8'h09, 32'h0000_0909, 1'b1);
    tick();
    idle_inputs();

`ifdef ARB_WATCHDOG_EN
    // Timeout after 16 PL_RUN cycles, then DRAIN, then DONE with err.
    start_run();
    for (int i = 0; i < 15; i++) tick();
    expect_status("wdog_still_run", 1'b1, 1'b0, 1'b0);
    tick();
    expect_status("wdog_drain", 1'b1, 1'b0, 1'b1);
    tick();
    expect_status("wdog_done", 1'b0, 1'b1, 1'b1);
    ps_clear = 1'b1;
    tick();
    idle_inputs();
    expect_status("wdog_clear", 1'b0, 1'b0, 1'b0);
`endif

    check_eq("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps_pl_mem_arbiter.md
Name: ps_pl_mem_arbiter

Overview:
- Owns the single shared result/operand memory (8-bit address, 32-bit data) between the PS bus side and the PL compute engine.
- Sequences ownership through the cycle: PS loads operands, PS starts, PL runs, PL finishes, PS reads back.
- Grants access per cycle only to the current owner and drives registered memory commands.
- Generates the launch pulse for the PL engine and exposes busy/done/error status to the PS.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 32, memory data width.
- WDOG_CYCLES, 1024, maximum cycles in PL_RUN before a timeout (used only with ARB_WATCHDOG_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ps_req  in  1  PS memory access request
- ps_we  in  1  PS write (1) / read (0)
- ps_addr  in  ADDR_W  PS address
- ps_wdata  in  DATA_W  PS write data
- ps_gnt  out  1  PS request accepted this cycle (combinational)
- ps_start  in  1  single-cycle pulse: hand memory to PL
- ps_clear  in  1  single-cycle pulse: acknowledge done, clear status
- pl_req  in  1  PL memory access request
- pl_we  in  1  PL write/read
- pl_addr  in  ADDR_W  PL address
- pl_wdata  in  DATA_W  PL write data
- pl_gnt  out  1  PL request accepted this cycle (combinational)
- pl_finish  in  1  PL computation complete (level or pulse)
- pl_launch  out  1  one-cycle start pulse to PL, registered
- mem_en  out  1  memory access strobe, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- busy  out  1  high in LAUNCH, PL_RUN, DRAIN
- done  out  1  high in DONE
- err  out  1  sticky error flag

Behaviour:
- Reset: state=PS_OWN. pl_launch, mem_en, mem_we, mem_addr, mem_wdata, busy, done and err all 0. Watchdog counter 0.
- Grants:
  - ps_gnt = ps_req and state in {PS_OWN, DONE}.
  - pl_gnt = pl_req and state == PL_RUN.
  - A denied requester holds its request; the block never queues it.
- Memory command:
  - On the cycle after a grant, mem_en=1 and mem_we/mem_addr/mem_wdata carry the granted requester's values. Latency is 1 cycle.
  - With no grant, mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last values.
- State machine:
  - PS_OWN: on ps_start go to LAUNCH.
  - LAUNCH: lasts one cycle; pl_launch=1 in the following cycle; no grants; then go to PL_RUN.
  - PL_RUN: on pl_finish go to DRAIN.
  - DRAIN: lasts one cycle; no grants, so the final PL command can complete; then go to DONE.
  - DONE: on ps_clear go to PS_OWN. On ps_start go to LAUNCH (relaunch without clearing).
- Simultaneous events:
  - ps_req together with ps_start in PS_OWN: the access is granted, then the state transitions.
  - pl_req together with pl_finish in PL_RUN: the access is granted, then the state goes to DRAIN.
  - ps_clear together with ps_start in DONE: ps_start wins.
- Errors:
  - ps_start in LAUNCH, PL_RUN or DRAIN is ignored and sets err.
  - pl_finish outside PL_RUN is ignored.
  - err is cleared only by ps_clear in DONE or by rst.
- Reset mid-run: rst in any state returns to PS_OWN on the next edge. Any in-flight command is dropped (mem_en=0).

Optional Feature:
- Macro: ARB_WATCHDOG_EN.
- With the macro defined:
  - A counter runs in PL_RUN and clears on entry to PL_RUN.
  - When it reaches WDOG_CYCLES-1 without pl_finish, the FSM goes to DRAIN, then DONE, with err=1.
  - pl_finish on the same cycle as the timeout counts as a normal finish; err is not set.
- Without the macro: no counter logic; PL_RUN waits indefinitely for pl_finish.

Decomposition:
- Shared package holds:
  - state enum/localparams: PS_OWN=0, LAUNCH=1, PL_RUN=2, DRAIN=3, DONE=4.
  - ADDR_W/DATA_W defaults.
- Optional sub-module: arb_watchdog (counter, clear, expire pulse), instantiated under ARB_WATCHDOG_EN.

Test Plan:
- PS writes 0xDEADBEEF to address 0x01 in PS_OWN: ps_gnt=1 the same cycle; next cycle mem_en=1, mem_we=1, mem_addr=0x01, mem_wdata=0xDEADBEEF.
- Full handshake (ps_start, PL writes 0x12345678 to 0x02 with pl_finish on the same cycle):
  - pl_launch is high for exactly 1 cycle.
  - The write appears on the memory port.
  - DRAIN lasts 1 cycle, then done=1.
  - A PS read of 0x02 is granted; ps_clear gives done=0.
- Ownership enforcement: ps_req in PL_RUN gives ps_gnt=0 and mem_en=0; pl_req in PS_OWN gives pl_gnt=0.
- ps_start during PL_RUN: state is unchanged and err=1. err stays 1 through DONE and is 0 after ps_clear.
- rst asserted in PL_RUN with pl_req high: the next cycle shows state PS_OWN, mem_en=0, busy=0 and every output at its reset value.
- With ARB_WATCHDOG_EN and WDOG_CYCLES=16: ps_start with no pl_finish leads to done=1 and err=1, 16 cycles after entering PL_RUN plus the DRAIN cycle.
